tag_allocator: RTL

- Free-list manager for the 32 ROB tags. Sits directly upstream of the ROB at dispatch.
- Hands a free Rd tag to dispatch (drives the ROB's Dispatch_Rd_tag, new_rd_tag and new_rd_tag_valid).
- Reclaims the tag when the ROB retires it (consumes Retire_valid / Retire_rd_tag).
- Returns every tag to the pool on a branch-mispredict flush.
- Internally a circular FIFO of tag values with head/tail pointers and an occupancy counter.

---
 rtl/tag_allocator_pkg.sv | 13 +
 rtl/tag_fifo_ptr.sv | 69 ++++++
 rtl/tag_allocator.sv | 108 ++++++++++
 3 files changed

// File: rtl/tag_allocator_pkg.sv
// Constants and encodings shared by the ROB, dispatch and the tag allocator.
package tag_allocator_pkg;

    localparam int ROB_TAG_W = 5;
    localparam int ROB_DEPTH = 32;

    typedef enum logic [1:0] {
        INST_RD_VALID = 2'b00,
        INST_BRANCH   = 2'b01,
        INST_STORE    = 2'b10
    } inst_type_e;

endpackage

// File: rtl/tag_fifo_ptr.sv
// Head/tail pointers and occupancy count for the tag free-list FIFO.
// Pointers wrap naturally; full/empty come only from the count.
module tag_fifo_ptr
    import tag_allocator_pkg::*;
#(
    parameter int TAG_W = ROB_TAG_W,
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             pop_i,
    input  logic             push_i,
    output logic [TAG_W-1:0] head_o,
    output logic [TAG_W-1:0] tail_o,
    output logic [TAG_W:0]   count_nxt_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = FULL_CNT;
        end else begin
            if (pop_i)  head_d = head_q + 1'b1;
            if (push_i) tail_d = tail_q + 1'b1;
            if (push_i && !pop_i)      count_d = count_q + 1'b1;
            else if (pop_i && !push_i) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FULL_CNT;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o      = head_q;
    assign tail_o      = tail_q;
    assign count_nxt_o = count_d;

    a_no_underflow: assert property (@(posedge clock) disable iff (reset)
        !(pop_i && !push_i && empty_o));
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push_i && !pop_i && full_o));
    a_count_range: assert property (@(posedge clock) disable iff (reset)
        count_q <= FULL_CNT);

endmodule

// File: rtl/tag_allocator.sv
// Free-list manager for ROB tags: offers the head tag to dispatch, reclaims
// retired tags, reloads on Flush. Optional TAG_CHECK_EN adds double-free checking.
module tag_allocator
    import tag_allocator_pkg::*;
#(
    parameter int TAG_W = ROB_TAG_W,
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Alloc_req,
    output logic [TAG_W-1:0] Alloc_tag,
    output logic             Alloc_valid,
    input  logic             Retire_valid,
    input  logic [TAG_W-1:0] Retire_rd_tag,
    input  logic             Flush,
    output logic [TAG_W:0]   Free_count,
`ifdef TAG_CHECK_EN
    output logic             Dup_free_err,
`endif
    output logic             Overflow_err
);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [TAG_W-1:0] head, tail;
    logic [TAG_W:0]   count_nxt;
    logic             empty, full;
    logic             alloc, free;
    logic [TAG_W:0]   free_count_q;
    logic             ovf_q;

    assign alloc = Alloc_req & ~empty;

`ifdef TAG_CHECK_EN
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             dup_q, dup_hit;

    // Free is judged against the pre-cycle busy state, so a same-cycle alloc can't legitimize it.
    assign dup_hit = Retire_valid & ~busy_q[Retire_rd_tag];
    assign free    = Retire_valid & ~full & busy_q[Retire_rd_tag];

    always_comb begin
        busy_d = busy_q;
        if (free)  busy_d[Retire_rd_tag] = 1'b0;
        if (alloc) busy_d[head]          = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            dup_q  <= 1'b0;
        end else if (Flush) begin
            busy_q <= '0;
            dup_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            dup_q  <= dup_hit;
        end
    end

    assign Dup_free_err = dup_q;
`else
    assign free = Retire_valid & ~full;
`endif

    tag_fifo_ptr #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) u_ptr (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (Flush),
        .pop_i       (alloc),
        .push_i      (free),
        .head_o      (head),
        .tail_o      (tail),
        .count_nxt_o (count_nxt),
        .empty_o     (empty),
        .full_o      (full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(i);
        end else if (Flush) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(i);
        end else if (free) begin
            mem_q[tail] <= Retire_rd_tag;
        end
    end

    // Overflow is sticky across Flush; only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q        <= 1'b0;
            free_count_q <= (TAG_W+1)'(DEPTH);
        end else begin
            if (!Flush && Retire_valid && full) ovf_q <= 1'b1;
            free_count_q <= count_nxt;
        end
    end

    assign Alloc_tag    = mem_q[head];
    assign Alloc_valid  = ~empty;
    assign Free_count   = free_count_q;
    assign Overflow_err = ovf_q;

endmodule
